ex_mdu: RTL

Iterative multiply/divide unit on the execute side of the ID/EX pipeline register. It consumes the registered operands and control for RV64M instructions (`MUL*`, `DIV*`, `REM*`, and their `W` forms). It computes the result over many cycles and holds the ID/EX register with a stall request until the result is ready. The result and destination register are presented to the EX/MEM path for one cycle.

---
 rtl/ex_mdu.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ex_mdu.sv
// Iterative RV64M multiply/divide unit fed from the ID/EX register.
// Radix-2 shift-add multiply and restoring divide, with divide-by-zero and overflow resolved at accept.
module ex_mdu #(
    parameter int unsigned XLEN = 64
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            ex_mdu_valid,
    input  logic [XLEN-1:0] ex_mdu_final_a,
    input  logic [XLEN-1:0] ex_mdu_final_b,
    input  logic [2:0]      ex_mdu_op,
    input  logic            ex_mdu_word_op,
    input  logic [4:0]      ex_mdu_rd,
    input  logic            ex_mdu_flush,
    output logic            mdu_stall,
    output logic            mdu_done,
    output logic [XLEN-1:0] mdu_result,
    output logic [4:0]      mdu_rd
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int unsigned CW = $clog2(XLEN + 1);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] aux_q, aux_d;
    logic [XLEN-1:0]   bmag_q, bmag_d;
    logic [2:0]        op_q, op_d;
    logic              word_q, word_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [4:0]        rd_lat_q, rd_lat_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_q, rd_d;

    logic              accept;
    logic              a_signed, b_signed, a_neg, b_neg, b_zero, ovf;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, dividend, spec_res;
    logic [XLEN:0]     rem_shift, rem_diff, rem_next;
    logic [2*XLEN-1:0] step_acc, step_aux, prod;
    logic [XLEN-1:0]   step_bmag, mul_res, quot, rem, div_sel, div_res, fin_res;

    assign accept    = (state_q == S_IDLE) && ex_mdu_valid && !ex_mdu_flush;
    assign mdu_stall = accept || (state_q == S_CALC);
    assign mdu_done   = done_q;
    assign mdu_result = result_q;
    assign mdu_rd     = rd_q;

    // Accept-time operand conditioning and special-case detection.
    always_comb begin
        a_signed = (ex_mdu_op == 3'd1) || (ex_mdu_op == 3'd2) || (ex_mdu_op == 3'd4) || (ex_mdu_op == 3'd6);
        b_signed = (ex_mdu_op == 3'd1) || (ex_mdu_op == 3'd4) || (ex_mdu_op == 3'd6);
        a_ext = ex_mdu_final_a;
        b_ext = ex_mdu_final_b;
        if (ex_mdu_word_op) begin
            a_ext = {{(XLEN-32){a_signed & ex_mdu_final_a[31]}}, ex_mdu_final_a[31:0]};
            b_ext = {{(XLEN-32){b_signed & ex_mdu_final_b[31]}}, ex_mdu_final_b[31:0]};
        end
        a_neg = a_signed & a_ext[XLEN-1];
        b_neg = b_signed & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
        b_zero = ex_mdu_word_op ? (ex_mdu_final_b[31:0] == 32'd0) : (ex_mdu_final_b == '0);
        ovf = ((ex_mdu_op == 3'd4) || (ex_mdu_op == 3'd6)) &&
              (ex_mdu_word_op ? ((ex_mdu_final_a[31:0] == 32'h8000_0000) && (ex_mdu_final_b[31:0] == '1))
                              : ((ex_mdu_final_a == {1'b1, {(XLEN-1){1'b0}}}) && (ex_mdu_final_b == '1)));
        dividend = ex_mdu_word_op ? {{(XLEN-32){ex_mdu_final_a[31]}}, ex_mdu_final_a[31:0]} : ex_mdu_final_a;
        if (b_zero)
            spec_res = ex_mdu_op[1] ? dividend : '1;
        else
            spec_res = ex_mdu_op[1] ? '0 : dividend;
    end

    // One iteration; the final result is formed from this step's outputs so completion lands with the last step.
    always_comb begin
        rem_shift = {acc_q[XLEN-1:0], aux_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, bmag_q};
        rem_next  = rem_diff[XLEN] ? rem_shift : rem_diff;
        if (op_q[2]) begin
            step_acc  = {{(XLEN-1){1'b0}}, rem_next};
            step_aux  = {{XLEN{1'b0}}, aux_q[XLEN-2:0], ~rem_diff[XLEN]};
            step_bmag = bmag_q;
        end else begin
            step_acc  = acc_q + (bmag_q[0] ? aux_q : '0);
            step_aux  = aux_q << 1;
            step_bmag = bmag_q >> 1;
        end
        prod    = qneg_q ? -step_acc : step_acc;
        mul_res = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        quot    = step_aux[XLEN-1:0];
        rem     = step_acc[XLEN-1:0];
        div_sel = op_q[1] ? (rneg_q ? -rem : rem) : (qneg_q ? -quot : quot);
        div_res = op_q[2] ? div_sel : mul_res;
        fin_res = word_q ? {{(XLEN-32){div_res[31]}}, div_res[31:0]} : div_res;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        aux_d    = aux_q;
        bmag_d   = bmag_q;
        op_d     = op_q;
        word_d   = word_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        rd_lat_d = rd_lat_q;
        done_d   = 1'b0;
        result_d = result_q;
        rd_d     = rd_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d     = ex_mdu_op;
                    word_d   = ex_mdu_word_op;
                    qneg_d   = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    rd_lat_d = ex_mdu_rd;
                    cnt_d    = ex_mdu_word_op ? CW'(32) : CW'(XLEN);
                    acc_d    = '0;
                    bmag_d   = b_mag;
                    if (ex_mdu_op[2] && ex_mdu_word_op)
                        aux_d = {{XLEN{1'b0}}, a_mag} << (XLEN - 32);
                    else
                        aux_d = {{XLEN{1'b0}}, a_mag};
                    if (ex_mdu_op[2] && (b_zero || ovf)) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = spec_res;
                        rd_d     = ex_mdu_rd;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d  = step_acc;
                aux_d  = step_aux;
                bmag_d = step_bmag;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = fin_res;
                    rd_d     = rd_lat_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (ex_mdu_flush) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
            rd_d     = rd_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            aux_q    <= '0;
            bmag_q   <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            rd_lat_q <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            aux_q    <= aux_d;
            bmag_q   <= bmag_d;
            op_q     <= op_d;
            word_q   <= word_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            rd_lat_q <= rd_lat_d;
            done_q   <= done_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

endmodule
